tbus_arbiter: RTL and testbench
===============================

# tbus_arbiter

Round-robin arbiter that shares one tristate bus among N drivers built from `tbuf`/`tinv` cells. It issues a one-hot grant that drives the driver enables directly. Between owners it inserts a programmable dead gap so that two drivers are never enabled at once. A maximum-hold timeout stops one requester from monopolising the bus.

## Interface
Parameters:
- N, 4, number of requesters (≥2)
- MAXHOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the timeout
- TURNAROUND, 1, dead cycles with all grants low between two tenures (0 allowed)

Ports:
- CLK  input  1  clock, all state changes on posedge
- RESET  input  1  asynchronous, active-low reset
- REQ  input  N  per-requester bus request, level, synchronous to CLK
- GNT  output  N  one-hot grant, registered; GNT[i] drives EN of driver i
- BUSY  output  1  registered, equals |GNT
- OWNER  output  max(1,clog2(N))  registered index of current/last owner
- TIMEOUT  output  1  registered one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT, TURN.
- Round-robin pointer PTR: search for the next owner starts at PTR and wraps mod N; the first REQ bit found wins. On release of owner i, PTR ← (i+1) mod N.
- IDLE: if any REQ is set at the edge, GNT ← onehot(winner), OWNER ← winner, hold count ← 1, go to GRANT. Otherwise stay in IDLE with GNT=0.
- GRANT, normal: while REQ[OWNER]=1 and (MAXHOLD=0 or hold count<MAXHOLD), keep GNT and increment hold count.
- GRANT, voluntary release: REQ[OWNER]=0 at the edge.
- GRANT, forced release: hold count=MAXHOLD with REQ[OWNER]=1. TIMEOUT ← 1 for one cycle.
- On either release with TURNAROUND>0: GNT ← 0, load the turn counter with TURNAROUND, go to TURN.
- On either release with TURNAROUND=0: arbitrate at the same edge using the updated PTR. GNT moves directly to the new winner, or to 0 and IDLE if no REQ is set.
- TURN: GNT=0, decrement the turn counter each cycle. The edge that ends the last TURN cycle arbitrates exactly as IDLE does, going to GRANT or IDLE. A REQ that drops during TURN is not considered.
- A timed-out requester that keeps REQ high stays eligible, but is lowest priority by the pointer rule.
- The arbiter never outputs a GNT with more than one bit set.
- Arithmetic:
  - hold counter width is clog2(MAXHOLD+1), saturating and never wrapping;
  - turn counter width is clog2(TURNAROUND+1);
  - PTR wrap is mod N, also for non-power-of-2 N.
- Reset (RESET=0, asynchronous): GNT=0, BUSY=0, OWNER=0, TIMEOUT=0, PTR=0, counters 0, state IDLE.
  - Reset takes effect mid-tenure immediately, without waiting for a clock edge.
  - After RESET deasserts, the first edge may grant.

## Timing
- Grant latency from IDLE: REQ sampled high at edge k gives GNT high from edge k, visible in cycle k+1. One cycle from REQ assertion.
- Release latency: REQ[OWNER] low before edge k gives GNT low after edge k.
- Gap between owners is exactly TURNAROUND cycles of GNT=0 when another REQ is pending.
- Maximum tenure is MAXHOLD cycles. TIMEOUT is high in the first cycle after the forced release, coincident with the first gap cycle.
- BUSY and OWNER update on the same edge as GNT. OWNER holds its last value while GNT=0.

## Test plan
- Reset: drive REQ=1111 with RESET low → GNT=0000, BUSY=0, OWNER=0, TIMEOUT=0. Release reset → GNT=0001 one edge later.
- Single requester (N=4, TURNAROUND=1): REQ=0100 from cycle 0 to 5 → GNT=0100 in cycles 1–6, 0000 from cycle 7, OWNER=2, TIMEOUT never high.
- Round robin with timeout (MAXHOLD=4, TURNAROUND=1): REQ=1111 held → GNT sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001…. TIMEOUT pulses in each 0000 cycle.
- Zero turnaround (TURNAROUND=0, MAXHOLD=0): REQ=0011, then drop REQ[0] in cycle 3 → GNT 0001 directly to 0010 with no gap. Popcount(GNT)≤1 on every cycle.
- Reset mid-grant: assert RESET asynchronously during GNT=1000 → GNT=0000 before the next edge. After release with REQ=1001, the winner is index 0 (PTR=0).
- Drop during TURN: REQ[1] pulses high only during the TURN cycle while REQ[3] stays high → REQ[1] is never granted, and the next grant is 1000.
- Assertion in all tests: never popcount(GNT)>1; with TURNAROUND≥1, never two different nonzero GNT values on consecutive cycles.

Source files
------------

// File: rtl/tbus_arbiter.sv
// Round-robin owner select for a shared tristate bus: one-hot grant drives the
// driver enables, with a programmable dead gap between owners and a hold timeout.
module tbus_arbiter #(
  parameter int N          = 4,
  parameter int MAXHOLD    = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [N-1:0]                          REQ,
  output logic [N-1:0]                          GNT,
  output logic                                  BUSY,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  OWNER,
  output logic                                  TIMEOUT
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);
  localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state_reg;
  logic [OW-1:0]   ptr_reg;
  logic [HW-1:0]   hold_reg;
  logic [TW-1:0]   turn_reg;

  logic [OW-1:0]   ptr_after_owner;
  logic [OW-1:0]   search_start;
  logic [OW:0]     pick;
  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic            keep_grant;

  // Returns {found, index} of the first set request scanning from start, mod N.
  function automatic logic [OW:0] rr_pick(input logic [N-1:0] req, input logic [OW-1:0] start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    ptr_after_owner = (OWNER == OW'(N - 1)) ? '0 : OWNER + 1'b1;
    // Leaving GRANT with no gap must already search from the post-release pointer.
    search_start = (state_reg == GRANT) ? ptr_after_owner : ptr_reg;
    pick         = rr_pick(REQ, search_start);
    win_found    = pick[OW];
    win_idx      = pick[OW-1:0];
    keep_grant   = REQ[OWNER] && ((MAXHOLD == 0) || (hold_reg < HOLD_MAX));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      hold_reg  <= '0;
      turn_reg  <= '0;
      GNT       <= '0;
      BUSY      <= 1'b0;
      OWNER     <= '0;
      TIMEOUT   <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            GNT       <= ONE_HOT0 << win_idx;
            BUSY      <= 1'b1;
            OWNER     <= win_idx;
            hold_reg  <= HW'(1);
            state_reg <= GRANT;
          end
        end

        GRANT: begin
          if (keep_grant) begin
            if (hold_reg != '1) hold_reg <= hold_reg + 1'b1;
          end else begin
            TIMEOUT <= REQ[OWNER];
            ptr_reg <= ptr_after_owner;
            if (TURNAROUND > 0) begin
              GNT       <= '0;
              BUSY      <= 1'b0;
              turn_reg  <= TURN_LOAD;
              state_reg <= TURN;
            end else if (win_found) begin
              GNT       <= ONE_HOT0 << win_idx;
              BUSY      <= 1'b1;
              OWNER     <= win_idx;
              hold_reg  <= HW'(1);
            end else begin
              GNT       <= '0;
              BUSY      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end

        TURN: begin
          if (turn_reg > TW'(1)) begin
            turn_reg <= turn_reg - 1'b1;
          end else begin
            turn_reg <= '0;
            if (win_found) begin
              GNT       <= ONE_HOT0 << win_idx;
              BUSY      <= 1'b1;
              OWNER     <= win_idx;
              hold_reg  <= HW'(1);
              state_reg <= GRANT;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          GNT       <= '0;
          BUSY      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed bench for tbus_arbiter: three instances cover default, short-timeout
// and zero-gap configurations; a monitor watches grant exclusivity every cycle.
module tb_tbus_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;
  logic [1:0] owner_a, owner_b, owner_c;
  logic       to_a, to_b, to_c;

  int n_checks = 0;
  int n_fail   = 0;

  tbus_arbiter #(.N(4), .MAXHOLD(16), .TURNAROUND(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .REQ(req_a), .GNT(gnt_a),
    .BUSY(busy_a), .OWNER(owner_a), .TIMEOUT(to_a));

  tbus_arbiter #(.N(4), .MAXHOLD(4), .TURNAROUND(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .REQ(req_b), .GNT(gnt_b),
    .BUSY(busy_b), .OWNER(owner_b), .TIMEOUT(to_b));

  tbus_arbiter #(.N(4), .MAXHOLD(0), .TURNAROUND(0)) dut_c (
    .CLK(CLK), .RESET(RESET), .REQ(req_c), .GNT(gnt_c),
    .BUSY(busy_c), .OWNER(owner_c), .TIMEOUT(to_c));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Exclusivity monitor; instances with a gap must never hop owner-to-owner.
  logic [3:0] prev_a, prev_b;
  always @(negedge CLK) begin
    if (!RESET) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      n_checks += 3;
      if ($countones(gnt_a) > 1) begin n_fail++; $display("FAIL onehot_a gnt=%b required popcount<=1", gnt_a); end
      if ($countones(gnt_b) > 1) begin n_fail++; $display("FAIL onehot_b gnt=%b required popcount<=1", gnt_b); end
      if ($countones(gnt_c) > 1) begin n_fail++; $display("FAIL onehot_c gnt=%b required popcount<=1", gnt_c); end
      n_checks += 2;
      if (prev_a != 0 && gnt_a != 0 && prev_a != gnt_a) begin
        n_fail++; $display("FAIL gap_a gnt %b -> %b required a dead cycle", prev_a, gnt_a);
      end
      if (prev_b != 0 && gnt_b != 0 && prev_b != gnt_b) begin
        n_fail++; $display("FAIL gap_b gnt %b -> %b required a dead cycle", prev_b, gnt_b);
      end
      prev_a = gnt_a;
      prev_b = gnt_b;
    end
  end

  task automatic do_reset();
    RESET = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    req_a = 4'b1111; req_b = '0; req_c = '0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks += 4;
    if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b required 0000", gnt_a); end
    if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b required 0", busy_a); end
    if (owner_a !== 2'd0)  begin n_fail++; $display("FAIL reset_owner got %0d required 0", owner_a); end
    if (to_a !== 1'b0)     begin n_fail++; $display("FAIL reset_timeout got %b required 0", to_a); end
    RESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b required 0001", gnt_a); end
    $display("test_reset done: gnt=%b busy=%b owner=%0d", gnt_a, busy_a, owner_a);
  endtask

  task automatic test_single();
    logic [3:0] exp_gnt;
    logic [1:0] exp_owner;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      exp_gnt   = (c >= 1 && c <= 6) ? 4'b0100 : 4'b0000;
      exp_owner = (c >= 1) ? 2'd2 : 2'd0;
      n_checks += 4;
      if (gnt_a !== exp_gnt)          begin n_fail++; $display("FAIL single_gnt c=%0d got %b required %b", c, gnt_a, exp_gnt); end
      if (busy_a !== (exp_gnt != 0))  begin n_fail++; $display("FAIL single_busy c=%0d got %b required %b", c, busy_a, exp_gnt != 0); end
      if (owner_a !== exp_owner)      begin n_fail++; $display("FAIL single_owner c=%0d got %0d required %0d", c, owner_a, exp_owner); end
      if (to_a !== 1'b0)              begin n_fail++; $display("FAIL single_timeout c=%0d got %b required 0", c, to_a); end
      req_a = (c <= 5) ? 4'b0100 : 4'b0000;
      @(negedge CLK);
    end
    $display("test_single done: gnt=%b owner=%0d", gnt_a, owner_a);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [1:0] exp_owner;
    logic       exp_to;
    int         p;
    do_reset();
    req_b = 4'b1111;
    for (int c = 0; c < 22; c++) begin
      if (c == 0) begin
        exp_gnt = 4'b0000; exp_owner = 2'd0; exp_to = 1'b0;
      end else begin
        p         = (c - 1) % 5;
        exp_owner = 2'(((c - 1) / 5) % 4);
        exp_gnt   = (p < 4) ? (4'b0001 << exp_owner) : 4'b0000;
        exp_to    = (p == 4);
      end
      n_checks += 3;
      if (gnt_b !== exp_gnt)     begin n_fail++; $display("FAIL rr_gnt c=%0d got %b required %b", c, gnt_b, exp_gnt); end
      if (to_b !== exp_to)       begin n_fail++; $display("FAIL rr_timeout c=%0d got %b required %b", c, to_b, exp_to); end
      if (owner_b !== exp_owner) begin n_fail++; $display("FAIL rr_owner c=%0d got %0d required %0d", c, owner_b, exp_owner); end
      @(negedge CLK);
    end
    $display("test_round_robin done: gnt=%b owner=%0d", gnt_b, owner_b);
  endtask

  task automatic test_zero_turn();
    logic [3:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_c = (c < 3) ? 4'b0011 : 4'b0010;
      exp_gnt = (c == 0) ? 4'b0000 : (c <= 3) ? 4'b0001 : 4'b0010;
      n_checks += 2;
      if (gnt_c !== exp_gnt) begin n_fail++; $display("FAIL zero_turn_gnt c=%0d got %b required %b", c, gnt_c, exp_gnt); end
      if (to_c !== 1'b0)     begin n_fail++; $display("FAIL zero_turn_timeout c=%0d got %b required 0", c, to_c); end
      @(negedge CLK);
    end
    $display("test_zero_turn done: gnt=%b owner=%0d", gnt_c, owner_c);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a = 4'b1000;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (gnt_a !== 4'b1000) begin n_fail++; $display("FAIL mid_setup got %b required 1000", gnt_a); end
    #2 RESET = 1'b0;
    #1;
    n_checks += 3;
    if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL mid_async_gnt got %b required 0000", gnt_a); end
    if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL mid_async_busy got %b required 0", busy_a); end
    if (owner_a !== 2'd0)  begin n_fail++; $display("FAIL mid_async_owner got %0d required 0", owner_a); end
    req_a = 4'b1001;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    n_checks += 2;
    if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant got %b required 0001", gnt_a); end
    if (owner_a !== 2'd0)  begin n_fail++; $display("FAIL mid_regrant_owner got %0d required 0", owner_a); end
    $display("test_reset_mid done: gnt=%b owner=%0d", gnt_a, owner_a);
  endtask

  task automatic test_drop_during_turn();
    do_reset();
    req_b = 4'b1001;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (gnt_b !== 4'b0001) begin n_fail++; $display("FAIL turn_setup got %b required 0001", gnt_b); end
    req_b = 4'b1000;
    @(negedge CLK);
    n_checks += 2;
    if (gnt_b !== 4'b0000) begin n_fail++; $display("FAIL turn_gap got %b required 0000", gnt_b); end
    if (to_b !== 1'b0)     begin n_fail++; $display("FAIL turn_timeout got %b required 0", to_b); end
    #1 req_b = 4'b1010;
    #2 req_b = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks += 2;
      if (gnt_b !== 4'b1000) begin n_fail++; $display("FAIL turn_next c=%0d got %b required 1000", c, gnt_b); end
      if (owner_b !== 2'd3)  begin n_fail++; $display("FAIL turn_owner c=%0d got %0d required 3", c, owner_b); end
    end
    $display("test_drop_during_turn done: gnt=%b owner=%0d", gnt_b, owner_b);
  endtask

  initial begin
    RESET = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_turn();
    test_reset_mid();
    test_drop_during_turn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
